// File: rtl/alu_pkg.sv
// Shared select codes, sequencer state encoding and select decode for the ALU command path.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

   function automatic logic is_supported(input logic [2:0] select);
      return (select == OP_ADD) || (select == OP_SUB) || (select == OP_NOT);
   endfunction

endpackage

// File: rtl/alu_seq.sv
// Command sequencer for an external 4-bit ALU: registers operands, waits SETTLE cycles,
// captures result/flags into a response register, and tracks sticky overflow and op count.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned W      = 4,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_select,
   input  logic             cmd_in_c,
   input  logic [W-1:0]     cmd_x,
   input  logic [W-1:0]     cmd_y,
   output logic [2:0]       alu_select,
   output logic             alu_in_c,
   output logic [W-1:0]     alu_x,
   output logic [W-1:0]     alu_y,
   input  logic [W-1:0]     alu_s,
   input  logic             alu_c,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_s,
   output logic             rsp_c,
   output logic             rsp_zero,
   output logic             rsp_overflow,
   output logic             rsp_err,
   input  logic             clr_sticky,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_e           state_q, state_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic [2:0]       sel_q, sel_d;
   logic             in_c_q, in_c_d;
   logic [W-1:0]     x_q, x_d, y_q, y_d;
   logic [W-1:0]     rs_q, rs_d;
   logic             rc_q, rc_d, rz_q, rz_d, rov_q, rov_d, rerr_q, rerr_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             accept, rsp_hs;

   // cmd_ready looks through rsp_ready so a new command can replace a consumed response.
   assign cmd_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign rsp_hs    = (state_q == RESP) && rsp_ready;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      sel_d    = sel_q;
      in_c_d   = in_c_q;
      x_d      = x_q;
      y_d      = y_q;
      rs_d     = rs_q;
      rc_d     = rc_q;
      rz_d     = rz_q;
      rov_d    = rov_q;
      rerr_d   = rerr_q;
      sticky_d = sticky_q & ~clr_sticky;
      count_d  = count_q + CNT_W'(rsp_hs);

      unique case (state_q)
         IDLE: ;
         ISSUE: begin
            if (settle_q == '0) begin
               rs_d    = alu_s;
               rc_d    = alu_c;
               rov_d   = alu_overflow;
               rz_d    = (alu_s == '0);
               rerr_d  = 1'b0;
               state_d = RESP;
               // Set after the clear term so a coincident clr_sticky loses.
               if (alu_overflow && ((sel_q == OP_ADD) || (sel_q == OP_SUB))) begin
                  sticky_d = 1'b1;
               end
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         sel_d  = cmd_select;
         in_c_d = cmd_in_c;
         x_d    = cmd_x;
         y_d    = cmd_y;
         if (is_supported(cmd_select)) begin
            state_d  = ISSUE;
            settle_d = SW'(SETTLE - 1);
         end else begin
            state_d = RESP;
            rs_d    = '0;
            rc_d    = 1'b0;
            rz_d    = 1'b0;
            rov_d   = 1'b0;
            rerr_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         settle_q <= '0;
         sel_q    <= '0;
         in_c_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         rs_q     <= '0;
         rc_q     <= 1'b0;
         rz_q     <= 1'b0;
         rov_q    <= 1'b0;
         rerr_q   <= 1'b0;
         sticky_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         sel_q    <= sel_d;
         in_c_q   <= in_c_d;
         x_q      <= x_d;
         y_q      <= y_d;
         rs_q     <= rs_d;
         rc_q     <= rc_d;
         rz_q     <= rz_d;
         rov_q    <= rov_d;
         rerr_q   <= rerr_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign alu_select   = sel_q;
   assign alu_in_c     = in_c_q;
   assign alu_x        = x_q;
   assign alu_y        = y_q;
   assign rsp_valid    = (state_q == RESP);
   assign rsp_s        = rs_q;
   assign rsp_c        = rc_q;
   assign rsp_zero     = rz_q;
   assign rsp_overflow = rov_q;
   assign rsp_err      = rerr_q;
   assign sticky_ovf   = sticky_q;
   assign op_count     = count_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: stand-in ALU, vector table, hand sequences, random traffic.
module tb_alu_seq;

   localparam int unsigned W      = 4;
   localparam int unsigned SETTLE = 1;
   localparam int unsigned CNT_W  = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid, cmd_ready, cmd_in_c;
   logic [2:0]       cmd_select;
   logic [W-1:0]     cmd_x, cmd_y;
   logic [2:0]       alu_select;
   logic             alu_in_c;
   logic [W-1:0]     alu_x, alu_y, alu_s;
   logic             alu_c, alu_overflow;
   logic             rsp_valid, rsp_ready;
   logic [W-1:0]     rsp_s;
   logic             rsp_c, rsp_zero, rsp_overflow, rsp_err;
   logic             clr_sticky, sticky_ovf;
   logic [CNT_W-1:0] op_count;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_count = 0;
   logic exp_sticky = 1'b0;

   always #5 clk = ~clk;

   alu_seq #(.W(W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_select(cmd_select),
      .cmd_in_c(cmd_in_c), .cmd_x(cmd_x), .cmd_y(cmd_y),
      .alu_select(alu_select), .alu_in_c(alu_in_c), .alu_x(alu_x), .alu_y(alu_y),
      .alu_s(alu_s), .alu_c(alu_c), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_c(rsp_c),
      .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
      .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .op_count(op_count)
   );

   // Stand-in external ALU; drives junk for unsupported selects so a wrong capture shows.
   logic [W-1:0] alu_b;
   logic [W:0]   alu_sum;
   always_comb begin
      alu_b        = (alu_select == 3'b001) ? ~alu_y : alu_y;
      alu_sum      = {1'b0, alu_x} + {1'b0, alu_b} + {{W{1'b0}}, alu_in_c};
      alu_s        = alu_sum[W-1:0];
      alu_c        = alu_sum[W];
      alu_overflow = (alu_x[W-1] == alu_b[W-1]) && (alu_s[W-1] != alu_x[W-1]);
      if (alu_select == 3'b010) begin
         alu_s        = ~alu_x;
         alu_c        = 1'b0;
         alu_overflow = 1'b0;
      end else if (alu_select > 3'b010) begin
         alu_s        = 4'hA;
         alu_c        = 1'b1;
         alu_overflow = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain unsigned/signed integer arithmetic on the operand values.
   function automatic void ref_op(input logic [2:0] sel, input logic inc,
                                  input logic [3:0] x, input logic [3:0] y,
                                  output logic [3:0] s, output logic c, output logic z,
                                  output logic ov, output logic err);
      int ux, uy, sx, sy, r, sr;
      ux = int'(x); uy = int'(y);
      sx = (ux >= 8) ? ux - 16 : ux;
      sy = (uy >= 8) ? uy - 16 : uy;
      s = 4'd0; c = 1'b0; ov = 1'b0; err = 1'b0;
      case (sel)
         3'd0: begin
            r = ux + uy + int'(inc); sr = sx + sy + int'(inc);
            s = 4'(r % 16); c = (r >= 16); ov = (sr > 7) || (sr < -8);
         end
         3'd1: begin
            r = ux + (15 - uy) + int'(inc); sr = sx + (-sy - 1) + int'(inc);
            s = 4'(r % 16); c = (r >= 16); ov = (sr > 7) || (sr < -8);
         end
         3'd2: s = 4'(15 - ux);
         default: err = 1'b1;
      endcase
      z = !err && (s == 4'd0);
   endfunction

   // One complete transaction from IDLE: offer, wait, backpressure for hold cycles, consume.
   task automatic do_cmd(input logic [2:0] sel, input logic inc, input logic [3:0] x,
                         input logic [3:0] y, input int hold, input logic [3:0] es,
                         input logic ec, input logic ez, input logic eov, input logic eerr);
      int lat;
      cmd_valid = 1'b1; cmd_select = sel; cmd_in_c = inc; cmd_x = x; cmd_y = y;
      #1;
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0; cmd_x = 4'($urandom); cmd_y = 4'($urandom);
      chk("alu_select", 32'(alu_select), 32'(sel));
      chk("alu_in_c", 32'(alu_in_c), 32'(inc));
      chk("alu_x", 32'(alu_x), 32'(x));
      chk("alu_y", 32'(alu_y), 32'(y));
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
         chk("alu_x_held", 32'(alu_x), 32'(x));
      end
      chk("latency", 32'(lat), eerr ? 32'd1 : 32'(SETTLE + 1));
      if (!eerr && eov) exp_sticky = 1'b1;
      chk("rsp_s", 32'(rsp_s), 32'(es));
      chk("rsp_c", 32'(rsp_c), 32'(ec));
      chk("rsp_zero", 32'(rsp_zero), 32'(ez));
      chk("rsp_overflow", 32'(rsp_overflow), 32'(eov));
      chk("rsp_err", 32'(rsp_err), 32'(eerr));
      chk("sticky_ovf", 32'(sticky_ovf), 32'(exp_sticky));
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; cmd_select = 3'($urandom); cmd_x = 4'($urandom);
         #1;
         chk("cmd_ready_bp", 32'(cmd_ready), 32'd0);
         tick();
         chk("rsp_valid_bp", 32'(rsp_valid), 32'd1);
         chk("rsp_s_bp", 32'(rsp_s), 32'(es));
         chk("alu_x_bp", 32'(alu_x), 32'(x));
         chk("alu_select_bp", 32'(alu_select), 32'(sel));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      chk("op_count", 32'(op_count), 32'(exp_count));
      chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("rsp_s_kept", 32'(rsp_s), 32'(es));
   endtask

   typedef struct {
      logic [2:0] sel;
      logic       inc;
      logic [3:0] x, y, s;
      logic       c, z, ov, err;
      int         hold;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [3:0] rs;
      logic rc, rz, rov, rerr;
      logic [2:0] sel;
      logic clr;

      vecs[0] = '{3'b000, 1'b0, 4'd3,  4'd5, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      vecs[1] = '{3'b001, 1'b1, 4'd5,  4'd5, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[2] = '{3'b010, 1'b0, 4'hA,  4'd3, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 3};
      vecs[3] = '{3'b101, 1'b0, 4'd7,  4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      vecs[4] = '{3'b000, 1'b0, 4'hF,  4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      vecs[5] = '{3'b001, 1'b1, 4'd2,  4'd3, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[6] = '{3'b001, 1'b1, 4'd8,  4'd1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 0};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_select = 3'd0; cmd_in_c = 1'b0;
      cmd_x = 4'd0; cmd_y = 4'd0; rsp_ready = 1'b0; clr_sticky = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu", 32'({alu_select, alu_in_c, alu_x, alu_y}), 32'd0);
      chk("rst_rsp", 32'({rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err}), 32'd0);
      chk("rst_sticky", 32'(sticky_ovf), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);

      // Reset while a command is in ISSUE discards it.
      cmd_valid = 1'b1; cmd_select = 3'b000; cmd_x = 4'd3; cmd_y = 4'd5;
      tick();
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rstmid_alu_x", 32'(alu_x), 32'd0);
      chk("rstmid_op_count", 32'(op_count), 32'd0);
      tick();
      chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rstmid_sticky", 32'(sticky_ovf), 32'd0);

      for (int i = 0; i < 7; i++) begin
         do_cmd(vecs[i].sel, vecs[i].inc, vecs[i].x, vecs[i].y, vecs[i].hold,
                vecs[i].s, vecs[i].c, vecs[i].z, vecs[i].ov, vecs[i].err);
      end

      // Back-to-back: consume a response and accept the next command in one cycle.
      cmd_valid = 1'b1; cmd_select = 3'b000; cmd_in_c = 1'b0; cmd_x = 4'd1; cmd_y = 4'd2;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("b2b_rsp_valid_a", 32'(rsp_valid), 32'd1);
      chk("b2b_rsp_s_a", 32'(rsp_s), 32'd3);
      rsp_ready = 1'b1; cmd_valid = 1'b1;
      cmd_select = 3'b001; cmd_in_c = 1'b1; cmd_x = 4'd9; cmd_y = 4'd4;
      #1;
      chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      chk("b2b_op_count_a", 32'(op_count), 32'(exp_count));
      chk("b2b_no_idle", 32'({rsp_valid, cmd_ready}), 32'd0);
      chk("b2b_alu_x", 32'(alu_x), 32'd9);
      tick();
      exp_sticky = 1'b1;
      chk("b2b_rsp_valid_b", 32'(rsp_valid), 32'd1);
      chk("b2b_rsp_b", 32'({rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err}),
          32'({4'd5, 1'b1, 1'b0, 1'b1, 1'b0}));
      chk("b2b_sticky", 32'(sticky_ovf), 32'(exp_sticky));
      rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_select = 3'b111; cmd_x = 4'd6;
      tick();
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      chk("b2b_err_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_err_rsp", 32'({rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err}), 32'd1);
      chk("b2b_err_alu_select", 32'(alu_select), 32'd7);
      chk("b2b_op_count_b", 32'(op_count), 32'(exp_count));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      chk("b2b_op_count_c", 32'(op_count), 32'(exp_count));
      chk("b2b_idle", 32'(rsp_valid), 32'd0);

      // Clear alone, then clear colliding with an overflow capture.
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      exp_sticky = 1'b0;
      chk("clr_sticky", 32'(sticky_ovf), 32'd0);
      cmd_valid = 1'b1; cmd_select = 3'b000; cmd_in_c = 1'b0; cmd_x = 4'd3; cmd_y = 4'd5;
      tick();
      cmd_valid = 1'b0; clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      exp_sticky = 1'b1;
      chk("collide_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("collide_sticky", 32'(sticky_ovf), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      chk("collide_op_count", 32'(op_count), 32'(exp_count));

      // Random traffic; enough transactions to wrap op_count.
      for (int i = 0; i < 300; i++) begin
         sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         clr = ($urandom_range(0, 4) == 0);
         if (clr) begin
            clr_sticky = 1'b1;
            tick();
            clr_sticky = 1'b0;
            exp_sticky = 1'b0;
         end
         cmd_in_c = 1'($urandom);
         cmd_x = 4'($urandom);
         cmd_y = 4'($urandom);
         ref_op(sel, cmd_in_c, cmd_x, cmd_y, rs, rc, rz, rov, rerr);
         do_cmd(sel, cmd_in_c, cmd_x, cmd_y, $urandom_range(0, 3), rs, rc, rz, rov, rerr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Command-side sequencer for the 4-bit combinational ALU (add / subtract / NOT).
- Accepts packed ALU commands over a valid/ready handshake, drives the ALU operand and select lines from registers, and waits a fixed settle time.
- Captures sum and flags into a response register, presented on a second valid/ready handshake.
- Also keeps a sticky overflow flag and a completed-operation counter for status readback.

Parameters:
W, 4, operand/result width
SETTLE, 1, cycles the ALU inputs are held before capture (>=1)
CNT_W, 8, width of op_count

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_select  in  3  operation: 000 add, 001 sub, 010 NOT x; others unsupported
cmd_in_c  in  1  subtract-enable / carry control passed to ALU
cmd_x  in  W  operand x
cmd_y  in  W  operand y
alu_select  out  3  registered select to ALU
alu_in_c  out  1  registered in_c to ALU
alu_x  out  W  registered x to ALU
alu_y  out  W  registered y to ALU
alu_s  in  W  ALU result
alu_c  in  1  ALU carry
alu_overflow  in  1  ALU signed overflow
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_s  out  W  captured result
rsp_c  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_overflow  out  1  captured overflow
rsp_err  out  1  unsupported select
clr_sticky  in  1  clear sticky_ovf
sticky_ovf  out  1  overflow seen since last clear
op_count  out  CNT_W  responses handed off, wraps

Behaviour:
- Clocking: one clock. Reset is synchronous, active-low, via rst_n.
- Reset values:
  - State is IDLE.
  - All alu_* outputs are 0.
  - rsp_valid, rsp_s, rsp_c, rsp_zero, rsp_overflow and rsp_err are 0.
  - sticky_ovf is 0 and op_count is 0.
- FSM states: IDLE, ISSUE, RESP.
- cmd_ready = (state==IDLE) || (state==RESP && rsp_ready). This is combinational from rsp_ready.
- Accept (cmd_valid && cmd_ready):
  - Load cmd_* into the alu_* registers.
  - Supported select: go to ISSUE with the settle counter set to SETTLE-1.
  - Unsupported select (011..111): go to RESP with rsp_err=1 and rsp_s/c/zero/overflow=0. The ALU is not used.
- ISSUE:
  - The alu_* outputs are held.
  - The counter decrements each cycle.
  - When the counter is 0: capture rsp_s=alu_s, rsp_c=alu_c, rsp_overflow=alu_overflow, rsp_zero=(alu_s==0), rsp_err=0, then go to RESP.
  - rsp_zero is always computed locally; the ALU's own zero flag is not used (it is undefined for select 010).
- Latency: accept in cycle N gives rsp_valid=1 in cycle N+SETTLE+1. An unsupported select gives rsp_valid=1 in cycle N+1.
- RESP:
  - rsp_valid=1, and all rsp_* values are stable until handshake.
  - alu_* outputs are held.
  - On rsp_ready with no new accept: go to IDLE, rsp_valid drops next cycle, and rsp_* data keeps its last value.
  - On rsp_ready with a simultaneous accept: go directly to ISSUE (or back to RESP for an unsupported select). There is no bubble cycle.
- op_count increments by 1 on every rsp handshake (including errors) and wraps from 2^CNT_W-1 to 0.
- sticky_ovf:
  - Set on capture when rsp_overflow=1 and select is 000 or 001.
  - Cleared by clr_sticky.
  - If set and clear happen in the same cycle, set wins.
- Reset mid-operation: rst_n low in any state returns all outputs to reset values on that edge. An in-flight command and any pending response are discarded without counting.
- cmd_* inputs are ignored whenever cmd_ready=0.

Decomposition:
- Shared package alu_pkg:
  - Select constants OP_ADD=3'b000, OP_SUB=3'b001, OP_NOT=3'b010.
  - The state enum {IDLE, ISSUE, RESP}.
  - A function is_supported(select).
- The ALU itself stays external and is wired at the parent level. No internal sub-module; the FSM, capture register and status counters live in one module.

Test Plan:
- Add 3+5: select=000, in_c=0, x=3, y=5, SETTLE=1 -> rsp_valid two cycles after accept; s=8, c=0, zero=0, overflow=1, sticky_ovf=1, op_count=1 after handshake.
- Subtract 5-5: select=001, in_c=1, x=5, y=5 -> s=0, c=1, zero=1, overflow=0, rsp_err=0.
- NOT with backpressure: select=010, x=1010b; hold rsp_ready=0 for 3 cycles -> s=0101b held stable; cmd_ready=0 throughout; alu_x stays 1010b.
- Back-to-back: rsp_ready=1 with the next cmd_valid in the same cycle -> cmd_ready=1, next command enters ISSUE with no IDLE cycle; op_count increments once per response.
- Unsupported select=101 -> rsp_valid next cycle with rsp_err=1 and s/c/zero/overflow=0; alu_select=101 but no capture from the ALU; op_count increments on handshake.
- Reset and sticky collision:
  - Drop rst_n during ISSUE -> next cycle IDLE, rsp_valid=0, op_count unchanged.
  - Separately, clr_sticky=1 in the same cycle as an overflow capture -> sticky_ovf=1.
